// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (SEXT/ZEXT/UPPER/BRANCH) with valid/ready handshake and tag sideband.
// Define IMM_EXT_SKID_EN for the two-entry skid variant with registered in_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int S = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] ext_val;

  always_comb begin
    sext_val = {{S{in_imm[IN_W-1]}}, in_imm};
    ext_val  = sext_val;
    case (in_mode)
      2'b00:   ext_val = sext_val;
      2'b01:   ext_val = {{S{1'b0}}, in_imm};
      2'b10:   ext_val = {in_imm, {S{1'b0}}};
      default: ext_val = sext_val << 2;
    endcase
  end

  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q,  out_data_d;
  logic [TAG_W-1:0]   out_tag_q,   out_tag_d;
  logic               accept;
  logic               drain;

  assign drain     = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef IMM_EXT_SKID_EN
  logic               skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0]   skid_data_q,  skid_data_d;
  logic [TAG_W-1:0]   skid_tag_q,   skid_tag_d;
  logic               in_ready_q,   in_ready_d;

  // in_ready is a flop mirroring an empty skid, so no path from out_ready.
  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q && !flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      // accept cannot coincide here: in_ready is low while the skid is full
      out_data_d   = skid_data_q;
      out_tag_d    = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || drain)) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_val;
      out_tag_d   = in_tag;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_val;
      skid_tag_d   = in_tag;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  // Single register: ready whenever it is empty or emptying this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_val;
      out_tag_d   = in_tag;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors, decoupled monitor, 12/20 parameter sweep.
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        sw_flush = 1'b0;
  logic        sw_in_valid = 1'b0;
  logic        sw_in_ready;
  logic [11:0] sw_in_imm = '0;
  logic [1:0]  sw_in_mode = '0;
  logic [2:0]  sw_in_tag = '0;
  logic        sw_out_valid;
  logic        sw_out_ready = 1'b1;
  logic [19:0] sw_out_data;
  logic [2:0]  sw_out_tag;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   held_exp;

  always #5 clk = ~clk;

  imm_extend_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(3)) u_sw (
    .clk(clk), .rst_n(rst_n), .flush(sw_flush),
    .in_valid(sw_in_valid), .in_ready(sw_in_ready), .in_imm(sw_in_imm),
    .in_mode(sw_in_mode), .in_tag(sw_in_tag),
    .out_valid(sw_out_valid), .out_ready(sw_out_ready),
    .out_data(sw_out_data), .out_tag(sw_out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Offer one request; returns just after the accepting edge.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic [31:0] exp);
    bit accepted = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    for (int i = 0; i < 100 && !accepted; i++) begin
      #4;
      if (in_ready) begin
        e.tag = tag; e.data = exp;
        sb.push_back(e);
        accepted = 1;
        $display("send tag=%0d imm=%h mode=%0d exp=%h", tag, imm, mode, exp);
      end
      @(posedge clk);
      if (!accepted) @(negedge clk);
    end
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL send_timeout: tag %0d never accepted, required acceptance", tag);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #4;
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: %0d entries still pending, required 0", name, sb.size());
    end
  endtask

  // Monitor: one comparison per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rst_n && !flush && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got tag=%0d data=%h, required no output", out_tag, out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag) begin
            errors++;
            $display("FAIL out_xfer: got tag=%0d data=%h, required tag=%0d data=%h",
                     out_tag, out_data, e.tag, e.data);
          end else begin
            $display("recv tag=%0d data=%h", out_tag, out_data);
          end
        end
      end
    end
  end

  task automatic sw_vec(input logic [11:0] imm, input logic [1:0] mode,
                        input logic [19:0] exp, input string name);
    @(negedge clk);
    sw_in_valid = 1'b1; sw_in_imm = imm; sw_in_mode = mode; sw_in_tag = 3'd5;
    #4;
    chk({name, "_ready"}, {31'd0, sw_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk(name, {12'd0, sw_out_data}, {12'd0, exp});
    chk({name, "_tag"}, {29'd0, sw_out_tag}, 32'd5);
  endtask

  initial begin
`ifdef IMM_EXT_SKID_EN
    held_exp = 2;
`else
    held_exp = 1;
`endif
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_tag",   {27'd0, out_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Extension modes, one-cycle latency
    send(16'h8001, 2'b00, 5'd3, 32'hFFFF8001);
    #1;
    chk("lat_sext_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_sext_data",  out_data, 32'hFFFF8001);
    chk("lat_sext_tag",   {27'd0, out_tag}, 32'd3);
    send(16'h8001, 2'b01, 5'd4, 32'h00008001);
    #1;
    chk("lat_zext_data",  out_data, 32'h00008001);
    send(16'h1234, 2'b10, 5'd5, 32'h12340000);
    send(16'hFFFF, 2'b11, 5'd6, 32'hFFFFFFFC);
    send(16'h7FFF, 2'b11, 5'd7, 32'h0001FFFC);
    idle();
    drain_wait("modes_drain");

    // Back-pressure stream of tags 1..6
    out_ready = 1'b1;
    fork
      begin
        send(16'h0001, 2'b00, 5'd1, 32'h00000001);
        send(16'h0002, 2'b01, 5'd2, 32'h00000002);
        send(16'h0003, 2'b10, 5'd3, 32'h00030000);
        send(16'hFFFE, 2'b00, 5'd4, 32'hFFFFFFFE);
        send(16'h8000, 2'b11, 5'd5, 32'hFFFE0000);
        send(16'h0010, 2'b11, 5'd6, 32'h00000040);
        idle();
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_tag",  {27'd0, out_tag}, 32'd1);
        chk("bp_held",      sb.size(), held_exp);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain_wait("bp_drain");

    // Flush with a simultaneous request while entries are held
    out_ready = 1'b0;
    send(16'h00AA, 2'b01, 5'd8, 32'h000000AA);
`ifdef IMM_EXT_SKID_EN
    send(16'h00BB, 2'b01, 5'd9, 32'h000000BB);
`endif
    @(negedge clk);
    in_valid = 1'b1; in_imm = 16'h5555; in_mode = 2'b01; in_tag = 5'd31; flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    send(16'h0C00, 2'b10, 5'd10, 32'h0C000000);
    idle();
    drain_wait("flush_drain");

    // Asynchronous reset between edges while holding data
    out_ready = 1'b0;
    send(16'h1111, 2'b00, 5'd11, 32'h00001111);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data",  out_data, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send(16'h8765, 2'b01, 5'd12, 32'h00008765);
    #1;
    chk("arst_first_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_first_data",  out_data, 32'h00008765);
    idle();
    drain_wait("arst_drain");

    // 12 -> 20 bit instance
    sw_vec(12'h800, 2'b00, 20'hFF800, "sw_sext");
    sw_vec(12'h800, 2'b01, 20'h00800, "sw_zext");
    sw_vec(12'h800, 2'b10, 20'h80000, "sw_upper");
    sw_vec(12'h800, 2'b11, 20'hFE000, "sw_branch");
    @(negedge clk);
    sw_in_valid = 1'b0;

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
